// File: rtl/mm_result_pkg.sv
// rtl/mm_result_pkg.sv - shared types and constants for the result collector
//
// Holds the collector state enum and the bit positions inside the sticky
// err vector. No ports.
package mm_result_pkg;

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_e;

  // err[ERR_DUP]  : a (row,col) cell was written twice in one fill pass
  // err[ERR_DROP] : a write was discarded (bad row address or arrived in DRAIN)
  localparam int ERR_DUP  = 0;
  localparam int ERR_DROP = 1;

endpackage

// File: rtl/mm_result_bank.sv
// rtl/mm_result_bank.sv - one column of result storage with per-row written flags
//
// Ports:
//   clk, reset      clock, asynchronous active-low reset (written flags only)
//   wr_en           write strobe, already qualified by the caller
//   wr_addr/wr_data row address and word to store
//   clr             clears every written flag (end of a drain pass)
//   rd_addr/rd_data combinational read port
//   written         one flag per row, set by a write since the last clear
module mm_result_bank #(
  parameter int ROW_NUM    = 32,
  parameter int WORD_WIDTH = 32,
  parameter int ADDR_WIDTH = $clog2(ROW_NUM)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [WORD_WIDTH-1:0] wr_data,
  input  logic                  clr,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [WORD_WIDTH-1:0] rd_data,
  output logic [ROW_NUM-1:0]    written
);

  // Data storage carries no reset: the written flags alone decide validity.
  logic [WORD_WIDTH-1:0] mem [ROW_NUM];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      written <= '0;
    end else if (clr) begin
      written <= '0;
    end else if (wr_en) begin
      written[wr_addr] <= 1'b1;
    end
  end

endmodule

// File: rtl/mm_result_collector.sv
// rtl/mm_result_collector.sv - gathers per-column results into rows, then streams rows out in order
//
// Optional feature macro: MM_RESULT_COLLECTOR_ERR_EN (sticky err tracking);
// without it err is tied to zero and the data path is unchanged.
//
// Ports:
//   clk, reset      clock, asynchronous active-low reset
//   row_data_out    per-column write data, column c in slice c
//   row_wraddr      per-column row address, column c in slice c
//   row_wr_en       per-column write strobe
//   wr_rdy          high while collecting (FILL)
//   out_val/out_rdy drained-row handshake
//   out_data        full row, column c in slice c
//   out_row_idx     index of the row on out_data
//   out_last        marks the final row of the matrix
//   err             bit0 duplicate write, bit1 dropped write (sticky)
module mm_result_collector
  import mm_result_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int ROW_NUM        = 32,
  parameter int COL_NUM        = 32,
  parameter int ROW_ADDR_WIDTH = $clog2(ROW_NUM)
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [DATA_WIDTH*4*COL_NUM-1:0]   row_data_out,
  input  logic [ROW_ADDR_WIDTH*COL_NUM-1:0] row_wraddr,
  input  logic [COL_NUM-1:0]                row_wr_en,
  output logic                              wr_rdy,
  output logic                              out_val,
  input  logic                              out_rdy,
  output logic [DATA_WIDTH*4*COL_NUM-1:0]   out_data,
  output logic [ROW_ADDR_WIDTH-1:0]         out_row_idx,
  output logic                              out_last,
  output logic [1:0]                        err
);

  localparam int WORD_WIDTH = 4 * DATA_WIDTH;
  localparam logic [ROW_ADDR_WIDTH:0]   ROW_LIMIT = (ROW_ADDR_WIDTH+1)'(ROW_NUM);
  localparam logic [ROW_ADDR_WIDTH-1:0] LAST_ROW  = ROW_ADDR_WIDTH'(ROW_NUM - 1);
  localparam logic [ROW_NUM-1:0]        ROW_ONE   = ROW_NUM'(1);

  state_e state_q, state_d;

  logic [COL_NUM-1:0]              col_wr;
  logic [COL_NUM-1:0]              col_full;
  logic [ROW_ADDR_WIDTH-1:0]       rd_addr;
  logic [DATA_WIDTH*4*COL_NUM-1:0] load_data;
  logic                            all_full;
  logic                            handshake;
  logic                            load_row;
  logic                            drain_done;
  logic [ROW_ADDR_WIDTH-1:0]       load_idx;

`ifdef MM_RESULT_COLLECTOR_ERR_EN
  logic [COL_NUM-1:0] col_dup;
  logic [COL_NUM-1:0] col_drop;
`endif

  assign wr_rdy    = (state_q == FILL);
  assign handshake = out_val & out_rdy;
  assign all_full  = &col_full;

  // In FILL the only row ever loaded is row 0; in DRAIN the read port looks
  // one row ahead so a handshake can load the successor on the same edge.
  assign rd_addr = (state_q == FILL) ? '0 : out_row_idx + 1'b1;

  for (genvar c = 0; c < COL_NUM; c++) begin : g_col
    logic [ROW_ADDR_WIDTH-1:0] col_addr;
    logic [WORD_WIDTH-1:0]     col_data;
    logic [WORD_WIDTH-1:0]     col_rd;
    logic [ROW_NUM-1:0]        col_written;
    logic [ROW_NUM-1:0]        col_mask;
    logic                      col_ok;

    assign col_addr  = row_wraddr[c*ROW_ADDR_WIDTH +: ROW_ADDR_WIDTH];
    assign col_data  = row_data_out[c*WORD_WIDTH +: WORD_WIDTH];
    assign col_ok    = {1'b0, col_addr} < ROW_LIMIT;
    assign col_wr[c] = (state_q == FILL) && row_wr_en[c] && col_ok;

    mm_result_bank #(
      .ROW_NUM   (ROW_NUM),
      .WORD_WIDTH(WORD_WIDTH),
      .ADDR_WIDTH(ROW_ADDR_WIDTH)
    ) u_bank (
      .clk    (clk),
      .reset  (reset),
      .wr_en  (col_wr[c]),
      .wr_addr(col_addr),
      .wr_data(col_data),
      .clr    (drain_done),
      .rd_addr(rd_addr),
      .rd_data(col_rd),
      .written(col_written)
    );

    // Completion counts this cycle's writes, so the flags are OR-ed with them.
    assign col_mask    = col_wr[c] ? (ROW_ONE << col_addr) : '0;
    assign col_full[c] = &(col_written | col_mask);

    // Row 0 may be written on the very edge that starts DRAIN; forward it
    // past the bank, whose read port still shows the old word.
    assign load_data[c*WORD_WIDTH +: WORD_WIDTH] =
      (col_wr[c] && (col_addr == '0)) ? col_data : col_rd;

`ifdef MM_RESULT_COLLECTOR_ERR_EN
    assign col_dup[c]  = col_wr[c] && col_written[col_addr];
    assign col_drop[c] = row_wr_en[c] && ((state_q == DRAIN) || !col_ok);
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= FILL;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    load_row   = 1'b0;
    load_idx   = '0;
    drain_done = 1'b0;
    unique case (state_q)
      FILL: begin
        if (all_full) begin
          state_d  = DRAIN;
          load_row = 1'b1;
        end
      end
      DRAIN: begin
        if (handshake) begin
          if (out_last) begin
            state_d    = FILL;
            drain_done = 1'b1;
          end else begin
            load_row = 1'b1;
            load_idx = out_row_idx + 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_val     <= 1'b0;
      out_data    <= '0;
      out_row_idx <= '0;
      out_last    <= 1'b0;
    end else if (load_row) begin
      out_val     <= 1'b1;
      out_data    <= load_data;
      out_row_idx <= load_idx;
      out_last    <= (load_idx == LAST_ROW);
    end else if (drain_done) begin
      out_val     <= 1'b0;
      out_row_idx <= '0;
      out_last    <= 1'b0;
    end
  end

`ifdef MM_RESULT_COLLECTOR_ERR_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err <= '0;
    end else begin
      err[ERR_DUP]  <= err[ERR_DUP]  | (|col_dup);
      err[ERR_DROP] <= err[ERR_DROP] | (|col_drop);
    end
  end
`else
  assign err = '0;
`endif

endmodule

// File: tb/tb_mm_result_collector.sv
// tb/tb_mm_result_collector.sv - self-checking bench for mm_result_collector
module tb_mm_result_collector;

  localparam int DW = 8;
  localparam int RN = 4;
  localparam int CN = 2;
  localparam int AW = 2;
  localparam int WW = 4 * DW;

`ifdef MM_RESULT_COLLECTOR_ERR_EN
  localparam bit ERR_ON = 1'b1;
`else
  localparam bit ERR_ON = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [WW*CN-1:0]  row_data_out = '0;
  logic [AW*CN-1:0]  row_wraddr = '0;
  logic [CN-1:0]     row_wr_en = '0;
  logic              out_rdy = 1'b0;
  logic              wr_rdy;
  logic              out_val;
  logic [WW*CN-1:0]  out_data;
  logic [AW-1:0]     out_row_idx;
  logic              out_last;
  logic [1:0]        err;

  int checks = 0;
  int errors = 0;
  logic chk_en = 1'b0;

  always #5 clk = ~clk;

  mm_result_collector #(
    .DATA_WIDTH(DW),
    .ROW_NUM   (RN),
    .COL_NUM   (CN)
  ) dut (
    .clk         (clk),
    .reset       (rst_n),
    .row_data_out(row_data_out),
    .row_wraddr  (row_wraddr),
    .row_wr_en   (row_wr_en),
    .wr_rdy      (wr_rdy),
    .out_val     (out_val),
    .out_rdy     (out_rdy),
    .out_data    (out_data),
    .out_row_idx (out_row_idx),
    .out_last    (out_last),
    .err         (err)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", name, got, exp);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  // Matrix of cells with a written flag each; a pass is "collect until every
  // cell is written, then hand rows out in order, one per accepted cycle".
  logic [31:0] m_mem [RN][CN];
  bit          m_wr  [RN][CN];
  bit          m_drain;
  int          m_row;
  logic [1:0]  m_err;
  int          m_a;
  bit          m_full;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_drain = 1'b0;
      m_row   = 0;
      m_err   = 2'b00;
      for (int r = 0; r < RN; r++)
        for (int c = 0; c < CN; c++) m_wr[r][c] = 1'b0;
    end else if (!m_drain) begin
      for (int c = 0; c < CN; c++) begin
        if (row_wr_en[c]) begin
          m_a = int'(row_wraddr[c*AW +: AW]);
          if (m_a >= RN) m_err[1] = 1'b1;
          else begin
            if (m_wr[m_a][c]) m_err[0] = 1'b1;
            m_mem[m_a][c] = row_data_out[c*WW +: WW];
            m_wr[m_a][c]  = 1'b1;
          end
        end
      end
      m_full = 1'b1;
      for (int r = 0; r < RN; r++)
        for (int c = 0; c < CN; c++) if (!m_wr[r][c]) m_full = 1'b0;
      if (m_full) begin
        m_drain = 1'b1;
        m_row   = 0;
      end
    end else begin
      if (row_wr_en != '0) m_err[1] = 1'b1;
      if (out_rdy) begin
        if (m_row == RN - 1) begin
          m_drain = 1'b0;
          m_row   = 0;
          for (int r = 0; r < RN; r++)
            for (int c = 0; c < CN; c++) m_wr[r][c] = 1'b0;
        end else begin
          m_row++;
        end
      end
    end
  end

  function automatic logic [1:0] exp_err();
    return ERR_ON ? m_err : 2'b00;
  endfunction

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      check("wr_rdy", 64'(wr_rdy), 64'(!m_drain));
      check("out_val", 64'(out_val), 64'(m_drain));
      check("err", 64'(err), 64'(exp_err()));
      if (m_drain) begin
        check("out_row_idx", 64'(out_row_idx), 64'(m_row));
        check("out_data", out_data, {m_mem[m_row][1], m_mem[m_row][0]});
        check("out_last", 64'(out_last), 64'(m_row == RN - 1));
      end else begin
        check("out_last_idle", 64'(out_last), 64'(0));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input logic [1:0] en, input int a0, input logic [31:0] d0,
                     input int a1, input logic [31:0] d1, input logic rdy);
    row_wr_en    = en;
    row_wraddr   = {a1[1:0], a0[1:0]};
    row_data_out = {d1, d0};
    out_rdy      = rdy;
    @(negedge clk);
  endtask

  task automatic idle(input logic rdy);
    cyc(2'b00, 0, 32'h0, 0, 32'h0, rdy);
  endtask

  task automatic fill_cell(input int i, input logic [31:0] base);
    int r;
    int c;
    logic [31:0] v;
    r = i / 2;
    c = i % 2;
    v = base + 32'(r * 16 + c);
    cyc((c == 0) ? 2'b01 : 2'b10, r, v, r, v, 1'b0);
  endtask

  task automatic fill_all(input logic [31:0] base);
    for (int i = 0; i < RN * CN; i++) fill_cell(i, base);
  endtask

  logic [1:0]  r_en;
  logic [31:0] r_d0, r_d1;

  initial begin
    repeat (2) @(negedge clk);
    check("rst_out_val", 64'(out_val), 64'(0));
    check("rst_out_data", out_data, 64'h0);
    check("rst_out_idx", 64'(out_row_idx), 64'(0));
    check("rst_out_last", 64'(out_last), 64'(0));
    check("rst_err", 64'(err), 64'(0));
    check("rst_wr_rdy", 64'(wr_rdy), 64'(1));
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk_en = 1'b1;

    // One cell per cycle, then a back-to-back drain.
    fill_all(32'h0);
    check("s1_val", 64'(out_val), 64'(1));
    check("s1_row0", out_data, 64'h00000001_00000000);
    idle(1'b1);
    check("s1_idx1", 64'(out_row_idx), 64'(1));
    idle(1'b1);
    idle(1'b1);
    check("s1_row3", out_data, 64'h00000031_00000030);
    check("s1_last", 64'(out_last), 64'(1));
    idle(1'b1);
    check("s1_done_val", 64'(out_val), 64'(0));
    check("s1_wr_rdy", 64'(wr_rdy), 64'(1));

    // Both columns at once, rows in reverse order.
    for (int r = 3; r >= 0; r--)
      cyc(2'b11, r, 32'h100 + 32'(r * 16), r, 32'h101 + 32'(r * 16), 1'b0);
    check("s2_val", 64'(out_val), 64'(1));
    check("s2_row0", out_data, 64'h00000101_00000100);
    repeat (3) idle(1'b1);
    check("s2_row3", out_data, 64'h00000131_00000130);
    idle(1'b1);

    // Backpressure on row 1.
    fill_all(32'h0);
    idle(1'b1);
    for (int k = 0; k < 3; k++) begin
      idle(1'b0);
      check("s3_hold_idx", 64'(out_row_idx), 64'(1));
      check("s3_hold_data", out_data, 64'h00000011_00000010);
    end
    idle(1'b1);
    check("s3_next_idx", 64'(out_row_idx), 64'(2));
    repeat (2) idle(1'b1);
    check("s3_err_clean", 64'(err), 64'(0));

    // Duplicate write on (row 2, col 0).
    cyc(2'b01, 2, 32'hAA, 0, 32'h0, 1'b0);
    cyc(2'b01, 2, 32'h55, 0, 32'h0, 1'b0);
    for (int i = 0; i < RN * CN; i++) if (i != 4) fill_cell(i, 32'h0);
    check("s4_err", 64'(err), 64'(ERR_ON ? 2'b01 : 2'b00));
    repeat (2) idle(1'b1);
    check("s4_dup_data", 64'(out_data[31:0]), 64'h55);

    // Write attempted during DRAIN.
    cyc(2'b01, 0, 32'hDEAD, 0, 32'h0, 1'b0);
    check("s5_err", 64'(err), 64'(ERR_ON ? 2'b11 : 2'b00));
    check("s5_data", 64'(out_data[31:0]), 64'h55);
    repeat (2) idle(1'b1);

    // Reset in the middle of a drain.
    fill_all(32'h40);
    repeat (2) idle(1'b1);
    check("s6_pre_idx", 64'(out_row_idx), 64'(2));
    #2 rst_n = 1'b0;
    #1 check("s6_async_val", 64'(out_val), 64'(0));
    check("s6_async_idx", 64'(out_row_idx), 64'(0));
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("s6_err_cleared", 64'(err), 64'(0));
    for (int i = 0; i < RN * CN - 1; i++) fill_cell(i, 32'h80);
    check("s6_not_yet", 64'(out_val), 64'(0));
    fill_cell(RN * CN - 1, 32'h80);
    check("s6_val", 64'(out_val), 64'(1));
    check("s6_row0", out_data, 64'h00000081_00000080);
    repeat (4) idle(1'b1);

    // Random traffic against the model.
    repeat (400) begin
      r_en = 2'($urandom);
      r_d0 = $urandom;
      r_d1 = $urandom;
      cyc(r_en, int'($urandom_range(0, 3)), r_d0, int'($urandom_range(0, 3)), r_d1,
          $urandom_range(0, 3) != 0);
    end
    repeat (8) idle(1'b1);
    chk_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mm_result_collector.md
MM_RESULT_COLLECTOR -- requirements
Module: mm_result_collector

Interface
REQ-001 Parameter DATA_WIDTH, default 8: element width; each column result is 4*DATA_WIDTH bits.
REQ-002 Parameter ROW_NUM, default 32: rows per result matrix.
REQ-003 Parameter COL_NUM, default 32: columns (write ports and banks).
REQ-004 Parameter ROW_ADDR_WIDTH, default $clog2(ROW_NUM): derived, never set manually.
REQ-005 Port clk, input, 1: single clock; all logic on rising edge.
REQ-006 Port reset, input, 1: asynchronous, active-low reset.
REQ-007 Port row_data_out, input, DATA_WIDTH*4*COL_NUM: per-column write data; column c in slice c.
REQ-008 Port row_wraddr, input, ROW_ADDR_WIDTH*COL_NUM: per-column row address; column c in slice c.
REQ-009 Port row_wr_en, input, COL_NUM: per-column write strobe.
REQ-010 Port wr_rdy, output, 1: high while collector accepts writes (FILL).
REQ-011 Port out_val, output, 1: drained row valid.
REQ-012 Port out_rdy, input, 1: downstream accepts row.
REQ-013 Port out_data, output, DATA_WIDTH*4*COL_NUM: full result row, column c in slice c.
REQ-014 Port out_row_idx, output, ROW_ADDR_WIDTH: index of row on out_data.
REQ-015 Port out_last, output, 1: high with out_val on row ROW_NUM-1.
REQ-016 Port err, output, 2: bit0 duplicate write, bit1 dropped write; sticky.

Function
REQ-017 Two states, FILL and DRAIN; reset enters FILL.
REQ-018 FILL: every column c with row_wr_en[c]=1 writes slice c of row_data_out to bank c at row_wraddr slice c, and sets written[row][c]; all columns independent in the same cycle.
REQ-019 Write to an already-written (row,col) in FILL overwrites data, leaves written unchanged, sets err[0].
REQ-020 Write address >= ROW_NUM is discarded and sets err[1].
REQ-021 When all ROW_NUM*COL_NUM written bits are set (including via writes in the current cycle), the next edge enters DRAIN and loads row 0 into the output register; out_val rises that edge.
REQ-022 DRAIN: wr_rdy=0; any row_wr_en bit high is discarded and sets err[1].
REQ-023 out_val, out_data, out_row_idx, out_last are registered and held stable while out_val=1 and out_rdy=0.
REQ-024 Handshake (out_val & out_rdy) on row r<ROW_NUM-1 loads row r+1 the same edge: no bubble, one row per cycle.
REQ-025 Handshake on row ROW_NUM-1: out_val falls, written bitmap clears, state returns to FILL; wr_rdy high next cycle.
REQ-026 Rows drain strictly in order 0..ROW_NUM-1; out_row_idx wraps to 0 only through FILL.

Reset
REQ-027 Assertion, at any time including mid-DRAIN: state FILL, written bitmap cleared, out_val=0, out_last=0, out_row_idx=0, out_data=0, err=0, wr_rdy=1 after deassertion.
REQ-028 Bank storage contents are not reset.

Configuration
REQ-029 Macro MM_RESULT_COLLECTOR_ERR_EN defined: err tracking per REQ-019/020/022.
REQ-030 Macro undefined: err tied to 0, no error logic; data behaviour unchanged (duplicates still overwrite, bad addresses/DRAIN writes still discarded).

Structure
REQ-031 Package mm_result_pkg holds the state enum (FILL, DRAIN) and err bit index constants.
REQ-032 One sub-module mm_result_bank, instantiated COL_NUM times: ROW_NUM x 4*DATA_WIDTH storage plus ROW_NUM written bits, one write port, one combinational read port.

Verification (DATA_WIDTH=8, ROW_NUM=4, COL_NUM=2)
REQ-033 Fill all 8 cells (value = row*16+col) one per cycle -> out_val rises edge after 8th write; rows 0..3 out with out_rdy=1 in 4 consecutive cycles, out_last on row 3, wr_rdy back high.
REQ-034 Both columns write rows 3,2,1,0 simultaneously -> DRAIN after 4 cycles, rows still drained 0..3 with correct data.
REQ-035 out_rdy low 3 cycles on row 1 -> out_data/out_row_idx=1 held stable, then row 2 next cycle.
REQ-036 Write (row 2,col 0)=0xAA then 0x55 -> row 2 col 0 drains 0x55, err=01 (ERR_EN); err=00 without macro.
REQ-037 row_wr_en=2'b01 during DRAIN -> data unchanged, err[1]=1.
REQ-038 reset asserted mid-DRAIN on row 2 -> out_val=0 immediately, next fill of 8 cells required before out_val rises.
